// File: rtl/bcd_scan_display.sv
// Multiplexed 7-segment driver for up to 8 BCD digits, with leading-zero blanking and a dash for codes 10..15.
// Latency: load to seg takes 2 edges; an, seg and digit_idx are registered together. There is no backpressure: load is always accepted.
module bcd_scan_display #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [2:0]              digit_idx,
   output logic                    frame_done
);

   localparam int             PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0]  PS_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [2:0]     IDX_LAST = 3'(NUM_DIGITS - 1);

   logic [PW-1:0]           prescaler;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic                    tick;
   logic [2:0]              idx_next;
   logic [3:0]              cur_digit;
   logic                    any_nz;
   logic                    sel_nz;
   logic                    blank;
   logic [6:0]              seg_next;
   logic [NUM_DIGITS-1:0]   an_next;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h40;
      endcase
   endfunction

   always_comb begin
      tick      = (prescaler == PS_LAST);
      idx_next  = digit_idx;
      cur_digit = 4'd0;
      any_nz    = 1'b0;
      sel_nz    = 1'b0;
      if (tick) begin
         idx_next = (digit_idx == IDX_LAST) ? 3'd0 : digit_idx + 3'd1;
      end
      // Walk from the top digit down so any_nz means "this digit or a higher one is nonzero".
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         any_nz = any_nz | (shadow[4*i +: 4] != 4'd0);
         if (i == int'(idx_next)) begin
            cur_digit = shadow[4*i +: 4];
            sel_nz    = any_nz;
         end
      end
      blank    = blank_lz && (idx_next != 3'd0) && !sel_nz;
      seg_next = blank ? 7'h00 : decode(cur_digit);
      an_next  = NUM_DIGITS'(1) << idx_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler  <= '0;
         digit_idx  <= 3'd0;
         shadow     <= '0;
         an         <= '0;
         seg        <= 7'h00;
         frame_done <= 1'b0;
      end else begin
         prescaler  <= tick ? '0 : prescaler + PW'(1);
         digit_idx  <= idx_next;
         frame_done <= tick && (digit_idx == IDX_LAST);
         if (load) begin
            shadow <= bcd_in;
         end
         an  <= an_next;
         seg <= seg_next;
      end
   end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display: a 4-digit scan instance plus a 1-digit, divide-by-1 instance fed like a mod10 counter.
module tb_bcd_scan_display;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        load;
   logic [15:0] bcd_in;
   logic        blank_lz;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [2:0]  digit_idx;
   logic        frame_done;

   logic        load1;
   logic [3:0]  bcd1;
   logic        blz1;
   logic [6:0]  seg1;
   logic [0:0]  an1;
   logic [2:0]  idx1;
   logic        fd1;

   int errors = 0;
   int checks = 0;

   bcd_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(4)) u_dut (
      .clk(clk), .reset(reset), .load(load), .bcd_in(bcd_in), .blank_lz(blank_lz),
      .seg(seg), .an(an), .digit_idx(digit_idx), .frame_done(frame_done)
   );

   bcd_scan_display #(.NUM_DIGITS(1), .SCAN_DIV(1)) u_dut1 (
      .clk(clk), .reset(reset), .load(load1), .bcd_in(bcd1), .blank_lz(blz1),
      .seg(seg1), .an(an1), .digit_idx(idx1), .frame_done(fd1)
   );

   task automatic test_reset();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if ({an, seg, frame_done, digit_idx, an1, seg1, fd1} !== {4'b0000, 7'h00, 1'b0, 3'd0, 1'b0, 7'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold cyc%0d: an=%b seg=%h fd=%b idx=%0d an1=%b seg1=%h fd1=%b, want all zero",
                     k, an, seg, frame_done, digit_idx, an1, seg1, fd1);
         end
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({an, seg, frame_done, digit_idx} !== {4'b0001, 7'h3F, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL reset_release: an=%b seg=%h fd=%b idx=%0d, want an=0001 seg=3f fd=0 idx=0",
                  an, seg, frame_done, digit_idx);
      end
   endtask

   task automatic test_scan(input string name, input logic [15:0] val, input logic blz,
                            input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
      logic [6:0] es [4];
      logic [3:0] ean;
      logic [2:0] eidx;
      logic       found;
      es[0] = s0; es[1] = s1; es[2] = s2; es[3] = s3;
      @(negedge clk);
      load = 1'b1; bcd_in = val; blank_lz = blz;
      @(negedge clk);
      load = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (frame_done === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL %s frame_start: frame_done=%b, want a pulse within 40 cycles", name, frame_done);
      end else begin
         for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            eidx = 3'(c / 4);
            ean  = 4'b0001 << eidx;
            checks++;
            if ({an, seg, frame_done, digit_idx} !== {ean, es[c/4], (c == 0), eidx}) begin
               errors++;
               $display("FAIL %s cyc%0d: an=%b seg=%h fd=%b idx=%0d, want an=%b seg=%h fd=%b idx=%0d",
                        name, c, an, seg, frame_done, digit_idx, ean, es[c/4], (c == 0), eidx);
            end
         end
      end
   endtask

   task automatic test_load_tick();
      logic found;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (frame_done === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL load_tick frame_start: frame_done=%b, want a pulse within 40 cycles", frame_done);
      end else begin
         repeat (3) @(negedge clk);
         load = 1'b1; bcd_in = 16'h1234;
         @(negedge clk);
         load = 1'b0;
         checks++;
         if ({an, seg} !== {4'b0010, 7'h40}) begin
            errors++;
            $display("FAIL load_tick_old: an=%b seg=%h, want an=0010 seg=40", an, seg);
         end
         @(negedge clk);
         checks++;
         if ({an, seg} !== {4'b0010, 7'h4F}) begin
            errors++;
            $display("FAIL load_tick_new: an=%b seg=%h, want an=0010 seg=4f", an, seg);
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic found;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (frame_done === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL midreset frame_start: frame_done=%b, want a pulse within 40 cycles", frame_done);
      end else begin
         repeat (8) @(negedge clk);
         checks++;
         if (digit_idx !== 3'd2) begin
            errors++;
            $display("FAIL midreset_pre: idx=%0d, want 2", digit_idx);
         end
         reset = 1'b1; load = 1'b1; bcd_in = 16'h9999;
         @(negedge clk);
         checks++;
         if ({an, seg, frame_done, digit_idx} !== {4'b0000, 7'h00, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL midreset_hold: an=%b seg=%h fd=%b idx=%0d, want an=0000 seg=00 fd=0 idx=0",
                     an, seg, frame_done, digit_idx);
         end
         reset = 1'b0;
         @(negedge clk);
         checks++;
         if ({an, seg, frame_done} !== {4'b0001, 7'h3F, 1'b0}) begin
            errors++;
            $display("FAIL midreset_rel1: an=%b seg=%h fd=%b, want an=0001 seg=3f fd=0", an, seg, frame_done);
         end
         @(negedge clk);
         load = 1'b0;
         checks++;
         if ({an, seg, frame_done} !== {4'b0001, 7'h6F, 1'b0}) begin
            errors++;
            $display("FAIL midreset_rel2: an=%b seg=%h fd=%b, want an=0001 seg=6f fd=0", an, seg, frame_done);
         end
         for (int n = 3; n < 16; n++) begin
            @(negedge clk);
            checks++;
            if (frame_done !== 1'b0) begin
               errors++;
               $display("FAIL midreset_nopulse cyc%0d: fd=%b, want 0", n, frame_done);
            end
         end
         @(negedge clk);
         checks++;
         if ({an, frame_done} !== {4'b0001, 1'b1}) begin
            errors++;
            $display("FAIL midreset_first_frame: an=%b fd=%b, want an=0001 fd=1", an, frame_done);
         end
      end
   endtask

   task automatic test_mod10();
      logic [6:0] tab [10];
      int         hist [30];
      tab[0] = 7'h3F; tab[1] = 7'h06; tab[2] = 7'h5B; tab[3] = 7'h4F; tab[4] = 7'h66;
      tab[5] = 7'h6D; tab[6] = 7'h7D; tab[7] = 7'h07; tab[8] = 7'h7F; tab[9] = 7'h6F;
      blz1 = 1'b1;
      load1 = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         checks++;
         if ({an1, fd1, idx1} !== {1'b1, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL mod10_ctl cyc%0d: an1=%b fd1=%b idx1=%0d, want an1=1 fd1=1 idx1=0", k, an1, fd1, idx1);
         end
         if (k >= 2) begin
            checks++;
            if (seg1 !== tab[hist[k-2]]) begin
               errors++;
               $display("FAIL mod10_seg cyc%0d: seg1=%h, want %h (q=%0d)", k, seg1, tab[hist[k-2]], hist[k-2]);
            end
         end
         hist[k] = k % 10;
         bcd1 = 4'(k % 10);
      end
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; bcd_in = 16'h0000; blank_lz = 1'b0;
      load1 = 1'b1; bcd1 = 4'd0; blz1 = 1'b1;
      test_reset();
      test_scan("scan_1234",       16'h1234, 1'b0, 7'h66, 7'h4F, 7'h5B, 7'h06);
      test_scan("blank_0070",      16'h0070, 1'b1, 7'h3F, 7'h07, 7'h00, 7'h00);
      test_scan("noblank_0070",    16'h0070, 1'b0, 7'h3F, 7'h07, 7'h3F, 7'h3F);
      test_scan("blank_0A00",      16'h0A00, 1'b1, 7'h3F, 7'h3F, 7'h40, 7'h00);
      test_scan("blank_0000",      16'h0000, 1'b1, 7'h3F, 7'h00, 7'h00, 7'h00);
      test_scan("scan_9876",       16'h9876, 1'b1, 7'h7D, 7'h07, 7'h7F, 7'h6F);
      test_scan("blank_05C5",      16'h05C5, 1'b1, 7'h6D, 7'h40, 7'h6D, 7'h00);
      test_load_tick();
      test_reset_midframe();
      test_mod10();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the mod-10 counter digits. Accepts up to 8 packed BCD digits, for example one digit per cascaded mod10 stage.
- Holds the digits in a shadow register and time-multiplexes them onto a common-cathode 7-segment display.
- Provides a prescaled digit scan, leading-zero blanking and a dash for invalid codes.
- Sits between the counter chain and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- SCAN_DIV, 4, clock cycles per digit slot; legal range >= 1. Use 4 in simulation and about 100000 on board.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  when high, bcd_in is captured into the shadow register at the clock edge.
- bcd_in  input  4*NUM_DIGITS  packed BCD; digit i is at [4i+3:4i], and digit 0 is least significant.
- blank_lz  input  1  leading-zero blanking enable.
- seg  output  7  registered segment drive {g,f,e,d,c,b,a}; 1 = lit.
- an  output  NUM_DIGITS  registered one-hot digit enable; 1 = digit active.
- digit_idx  output  3  registered index of the digit currently driven.
- frame_done  output  1  registered 1-cycle pulse at the end of each full scan.

Behaviour:
- One clock. Reset is synchronous and active-high; ports are named clk and reset.
- Reset (at the edge where reset=1):
  - prescaler=0, digit_idx=0, shadow=0.
  - an=0, seg=0, frame_done=0.
  - load is ignored while reset=1.
  - Reset mid-frame aborts the scan immediately, with no partial-frame pulse.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick = (prescaler == SCAN_DIV-1).
  - SCAN_DIV=1 gives tick every cycle.
- digit_idx:
  - On tick, increments, wrapping NUM_DIGITS-1 -> 0.
  - NUM_DIGITS=1 keeps it at 0.
- frame_done: 1 for exactly the cycle after the edge where tick=1 and digit_idx==NUM_DIGITS-1; otherwise 0.
- Shadow register:
  - Captures bcd_in on the edge with load=1; holds otherwise.
  - load held high simply tracks bcd_in with 1 cycle of latency.
- Outputs (registered every non-reset edge from the post-edge digit_idx and the pre-edge shadow):
  - an = one-hot(new digit_idx), so an, seg and digit_idx always change together.
  - seg = decode(shadow digit[new digit_idx]), giving load-to-seg latency of 2 edges.
  - In the first cycle after reset release, an=...0001 and seg shows shadow digit 0.
- Decode (hex, {g..a}):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10..15 show a dash, 40.
- Leading-zero blanking (blank_lz=1):
  - Digit i>0 gets seg=00 if digit i and all higher digits equal 0.
  - Digit 0 is never blanked.
  - Invalid codes count as nonzero.
  - an stays asserted for blanked digits.
- blank_lz is sampled live and is not shadowed.
- Simultaneous load and tick: both take effect; the new digit shows the old shadow for 1 cycle, then the new value.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4):
- Reset for 3 cycles, then release -> during reset an=0000, seg=00, frame_done=0. The first edge after release gives an=0001, digit_idx=0, seg=3F.
- load bcd_in=16'h1234, blank_lz=0 -> an steps 0001,0010,0100,1000 every 4 cycles with seg 66,4F,5B,06. frame_done pulses exactly once per 16 cycles, in the cycle an returns to 0001.
- load 16'h0070, blank_lz=1 -> digit0 shows 3F and digit1 shows 07. Digits 2 and 3 show seg=00 with an still one-hot. With blank_lz=0 the same value shows 3F on digits 2 and 3.
- load 16'h0A00, blank_lz=1 -> digit2 shows 40, digits 1 and 0 show 3F, digit3 is blanked. load 16'h0000 -> only digit0 is lit, showing 3F.
- Drive bcd_in[3:0] from mod10 q with load=1 and SCAN_DIV=1, NUM_DIGITS=1 -> seg cycles 3F,06,...,6F,3F, each lagging q by 2 clock edges. frame_done is high every cycle.
- Assert reset for 1 cycle while digit_idx=2, with load=1 and bcd_in=16'h9999 -> the next edge gives idx=0, an=0000, shadow=0. After release, digit 0 shows 6F only because load is still 1, with 2-edge latency.
